// File: rtl/alu_issue_pkg.sv
// alu_issue_pkg: opcode constants, instruction field positions and datapath defaults
// shared by the issue stage, register file and ALU.
package alu_issue_pkg;
    localparam int XLEN_DEF = 32;
    localparam int OP_MSB   = 31;
    localparam int OP_LSB   = 28;
    localparam int RD_MSB   = 27;
    localparam int RD_LSB   = 25;
    localparam int RS1_MSB  = 24;
    localparam int RS1_LSB  = 22;
    localparam int RS2_MSB  = 21;
    localparam int RS2_LSB  = 19;
    localparam int IMM_SEL  = 18;
    localparam int IMM_MSB  = 15;
    localparam int IMM_LSB  = 0;

    typedef enum logic [3:0] {
        OP_ADD = 4'd1,
        OP_SUB = 4'd2,
        OP_AND = 4'd3,
        OP_OR  = 4'd4,
        OP_XOR = 4'd5,
        OP_SLL = 4'd6,
        OP_SRL = 4'd7
    } alu_op_e;

    function automatic logic is_legal(input logic [3:0] op);
        return (op >= OP_ADD) && (op <= OP_SRL);
    endfunction
endpackage

// File: rtl/regfile.sv
// regfile: NREGS x XLEN registers, two asynchronous read ports, one synchronous
// write port; r0 is hardwired to zero.
module regfile
    import alu_issue_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREGS = 8,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [AW-1:0]   raddr1,
    input  logic [AW-1:0]   raddr2,
    output logic [XLEN-1:0] rdata1,
    output logic [XLEN-1:0] rdata2,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [XLEN-1:0] wdata
);
    logic [XLEN-1:0] mem_q [NREGS];
    logic [XLEN-1:0] mem_d [NREGS];

    always_comb begin
        mem_d = mem_q;
        if (we && waddr != '0) mem_d[waddr] = wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) mem_q[i] <= '0;
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rdata1 = (raddr1 == '0) ? '0 : mem_q[raddr1];
    assign rdata2 = (raddr2 == '0) ? '0 : mem_q[raddr2];
endmodule

// File: rtl/alu_issue.sv
// alu_issue: decodes one instruction per cycle, reads operands (with writeback
// bypass) and holds them in a valid/ready output register for the ALU.
module alu_issue
    import alu_issue_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREGS = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr,
    input  logic            wb_en,
    input  logic [2:0]      wb_addr,
    input  logic [XLEN-1:0] wb_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] operand1,
    output logic [XLEN-1:0] operand2,
    output logic [3:0]      opcode,
    output logic [2:0]      out_rd,
    output logic            illegal
);
    localparam int AW = $clog2(NREGS);

    logic [3:0]      op_f;
    logic [2:0]      rd_f, rs1_f, rs2_f;
    logic            use_imm;
    logic [15:0]     imm_f;
    logic            unused_bits;
    logic [XLEN-1:0] rd1, rd2, op1_byp, op2_sel;
    logic            fire_in, fire_out, legal;

    logic            valid_q, valid_d, illegal_q, illegal_d;
    logic [XLEN-1:0] op1_q, op1_d, op2_q, op2_d;
    logic [3:0]      opc_q, opc_d;
    logic [2:0]      rd_q, rd_d;

    assign op_f        = instr[OP_MSB:OP_LSB];
    assign rd_f        = instr[RD_MSB:RD_LSB];
    assign rs1_f       = instr[RS1_MSB:RS1_LSB];
    assign rs2_f       = instr[RS2_MSB:RS2_LSB];
    assign use_imm     = instr[IMM_SEL];
    assign imm_f       = instr[IMM_MSB:IMM_LSB];
    assign unused_bits = ^instr[17:16];

    regfile #(.XLEN(XLEN), .NREGS(NREGS), .AW(AW)) u_rf (
        .clk    (clk),
        .rst_n  (rst_n),
        .raddr1 (AW'(rs1_f)),
        .raddr2 (AW'(rs2_f)),
        .rdata1 (rd1),
        .rdata2 (rd2),
        .we     (wb_en),
        .waddr  (AW'(wb_addr)),
        .wdata  (wb_data)
    );

    assign in_ready = !valid_q || out_ready;
    assign fire_in  = in_valid && in_ready;
    assign fire_out = valid_q && out_ready;
    assign legal    = is_legal(op_f);

    // Same-cycle writeback wins over the array, which only updates at the edge.
    assign op1_byp = (wb_en && wb_addr == rs1_f && rs1_f != '0) ? wb_data : rd1;
    assign op2_sel = use_imm ? XLEN'(imm_f)
                   : (wb_en && wb_addr == rs2_f && rs2_f != '0) ? wb_data : rd2;

    always_comb begin
        valid_d   = valid_q;
        op1_d     = op1_q;
        op2_d     = op2_q;
        opc_d     = opc_q;
        rd_d      = rd_q;
        illegal_d = fire_in && !legal;
        if (fire_in && legal) begin
            valid_d = 1'b1;
            op1_d   = op1_byp;
            op2_d   = op2_sel;
            opc_d   = op_f;
            rd_d    = rd_f;
        end else if (fire_out) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            illegal_q <= 1'b0;
            op1_q     <= '0;
            op2_q     <= '0;
            opc_q     <= '0;
            rd_q      <= '0;
        end else begin
            valid_q   <= valid_d;
            illegal_q <= illegal_d;
            op1_q     <= op1_d;
            op2_q     <= op2_d;
            opc_q     <= opc_d;
            rd_q      <= rd_d;
        end
    end

    assign out_valid = valid_q;
    assign illegal   = illegal_q;
    assign operand1  = op1_q;
    assign operand2  = op2_q;
    assign opcode    = opc_q;
    assign out_rd    = rd_q;
endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: directed vectors with hand-computed expectations for alu_issue.
module tb_alu_issue;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] instr = '0;
    logic        wb_en = 1'b0;
    logic [2:0]  wb_addr = '0;
    logic [31:0] wb_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] operand1, operand2;
    logic [3:0]  opcode;
    logic [2:0]  out_rd;
    logic        illegal;

    int vectors = 0;
    int miscompares = 0;

    alu_issue #(.XLEN(32), .NREGS(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .instr     (instr),
        .wb_en     (wb_en),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .operand1  (operand1),
        .operand2  (operand2),
        .opcode    (opcode),
        .out_rd    (out_rd),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mk(input logic [3:0] op, input logic [2:0] rd,
                                       input logic [2:0] rs1, input logic [2:0] rs2,
                                       input logic ui, input logic [15:0] imm,
                                       input logic [1:0] ign);
        return {op, rd, rs1, rs2, ui, ign, imm};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [31:0] o1, input logic [31:0] o2,
                           input logic [3:0] opc, input logic [2:0] rd);
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_op1"}, operand1, o1);
        chk({tag, "_op2"}, operand2, o2);
        chk({tag, "_opc"}, 32'(opcode), 32'(opc));
        chk({tag, "_rd"}, 32'(out_rd), 32'(rd));
    endtask

    initial begin
        #1;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_illegal", 32'(illegal), 32'd0);
        chk("rst_op1", operand1, 32'd0);
        chk("rst_opc", 32'(opcode), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        #11 rst_n = 1'b1;
        tick();

        wb_en = 1'b1; wb_addr = 3'd1; wb_data = 32'd50;
        tick();
        wb_addr = 3'd2; wb_data = 32'd10;
        tick();
        wb_en = 1'b0;
        in_valid = 1'b1; instr = mk(4'd1, 3'd3, 3'd1, 3'd2, 1'b0, 16'd0, 2'b00);
        tick();
        chk_out("add", 32'd50, 32'd10, 4'd1, 3'd3);

        wb_en = 1'b1; wb_addr = 3'd1; wb_data = 32'd7;
        instr = mk(4'd5, 3'd4, 3'd1, 3'd1, 1'b0, 16'd0, 2'b00);
        tick();
        wb_en = 1'b0;
        chk_out("xor_byp", 32'd7, 32'd7, 4'd5, 3'd4);

        instr = mk(4'd2, 3'd5, 3'd1, 3'd2, 1'b0, 16'd0, 2'b00);
        tick();
        chk_out("sub", 32'd7, 32'd10, 4'd2, 3'd5);

        out_ready = 1'b0;
        instr = mk(4'd4, 3'd6, 3'd1, 3'd2, 1'b0, 16'd0, 2'b00);
        wb_en = 1'b1; wb_addr = 3'd2; wb_data = 32'd20;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_in_ready", 32'(in_ready), 32'd0);
            tick();
            wb_en = 1'b0;
            chk_out("stall_hold", 32'd7, 32'd10, 4'd2, 3'd5);
        end
        out_ready = 1'b1;
        #1;
        chk("resume_in_ready", 32'(in_ready), 32'd1);
        tick();
        chk_out("or_b2b", 32'd7, 32'd20, 4'd4, 3'd6);

        instr = mk(4'b1001, 3'd7, 3'd1, 3'd2, 1'b0, 16'd0, 2'b00);
        tick();
        chk("ill_pulse", 32'(illegal), 32'd1);
        chk("ill_valid", 32'(out_valid), 32'd0);
        in_valid = 1'b0;
        tick();
        chk("ill_clear", 32'(illegal), 32'd0);
        chk("ill_valid2", 32'(out_valid), 32'd0);

        in_valid = 1'b1; instr = mk(4'd6, 3'd7, 3'd1, 3'd3, 1'b1, 16'h0004, 2'b11);
        tick();
        chk_out("sll_imm", 32'd7, 32'd4, 4'd6, 3'd7);
        chk("sll_illegal", 32'(illegal), 32'd0);

        in_valid = 1'b0; out_ready = 1'b0;
        tick();
        chk("stall2_valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_op1", operand1, 32'd0);
        chk("arst_op2", operand2, 32'd0);
        chk("arst_rd", 32'(out_rd), 32'd0);
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        #2 rst_n = 1'b1;
        tick();

        out_ready = 1'b1;
        in_valid = 1'b1; instr = mk(4'd1, 3'd1, 3'd1, 3'd2, 1'b0, 16'd0, 2'b00);
        tick();
        chk_out("post_rst", 32'd0, 32'd0, 4'd1, 3'd1);

        in_valid = 1'b0; wb_en = 1'b1; wb_addr = 3'd0; wb_data = 32'd99;
        tick();
        wb_en = 1'b0;
        in_valid = 1'b1; instr = mk(4'd3, 3'd2, 3'd0, 3'd0, 1'b0, 16'd0, 2'b00);
        tick();
        chk_out("r0_zero", 32'd0, 32'd0, 4'd3, 3'd2);

        wb_en = 1'b1; wb_addr = 3'd0; wb_data = 32'd55;
        instr = mk(4'd7, 3'd3, 3'd0, 3'd0, 1'b0, 16'd0, 2'b00);
        tick();
        wb_en = 1'b0; in_valid = 1'b0;
        chk_out("r0_nobyp", 32'd0, 32'd0, 4'd7, 3'd3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
